fetch_pc_unit: RTL and testbench



---
 rtl/fetch_pc_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch register feeding decode over a valid/ready handshake.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters on perf_fetches/perf_stalls.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_LIMIT = 16'd32,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  input  logic [15:0] instruction,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir_instr,
  output logic [15:0] ir_pc,
  output logic [15:0] ir_pc_next,
  output logic        halted,
  output logic [15:0] perf_fetches,
  output logic [15:0] perf_stalls
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic [15:0] ir_instr_q, ir_instr_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic [15:0] ir_pc_next_q, ir_pc_next_d;
  logic        halted_q, halted_d;

  logic redirect_take;
  logic load;
  logic capture;
  logic stall;

  assign redirect_take = redirect_valid && (state_q != BOOT);
  assign load          = (state_q == RUN) && (pc_q < PC_LIMIT) && (!ir_valid_q || ir_ready);
  // A redirect in the same cycle wins, so the load never actually captures.
  assign capture       = load && !redirect_take;
  assign stall         = ir_valid_q && !ir_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_valid_d   = ir_valid_q;
    ir_instr_d   = ir_instr_q;
    ir_pc_d      = ir_pc_q;
    ir_pc_next_d = ir_pc_next_q;
    halted_d     = halted_q;
    if (redirect_take) begin
      pc_d       = {redirect_pc[15:1], 1'b0};
      ir_valid_d = 1'b0;
      state_d    = RUN;
      halted_d   = 1'b0;
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (pc_q >= PC_LIMIT) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
          if (capture) begin
            ir_instr_d   = instruction;
            ir_pc_d      = pc_q;
            ir_pc_next_d = pc_q + PC_STEP;
            ir_valid_d   = 1'b1;
            pc_d         = pc_q + PC_STEP;
          end else if (ir_valid_q && ir_ready) begin
            ir_valid_d = 1'b0;
          end
        end
        HALT: begin
          // The last fetched word still drains to decode.
          if (ir_valid_q && ir_ready) ir_valid_d = 1'b0;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ir_valid_q   <= 1'b0;
      ir_instr_q   <= 16'h0000;
      ir_pc_q      <= 16'h0000;
      ir_pc_next_q <= 16'h0000;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_valid_q   <= ir_valid_d;
      ir_instr_q   <= ir_instr_d;
      ir_pc_q      <= ir_pc_d;
      ir_pc_next_q <= ir_pc_next_d;
      halted_q     <= halted_d;
    end
  end

  assign pc         = pc_q;
  assign ir_valid   = ir_valid_q;
  assign ir_instr   = ir_instr_q;
  assign ir_pc      = ir_pc_q;
  assign ir_pc_next = ir_pc_next_q;
  assign halted     = halted_q;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetches_q, perf_fetches_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_fetches_d = perf_fetches_q;
    perf_stalls_d  = perf_stalls_q;
    if (capture && perf_fetches_q != 16'hFFFF) perf_fetches_d = perf_fetches_q + 16'd1;
    if (stall && perf_stalls_q != 16'hFFFF)    perf_stalls_d  = perf_stalls_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetches_q <= 16'h0000;
      perf_stalls_q  <= 16'h0000;
    end else begin
      perf_fetches_q <= perf_fetches_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_fetches = perf_fetches_q;
  assign perf_stalls  = perf_stalls_q;
`else
  assign perf_fetches = 16'h0000;
  assign perf_stalls  = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: ROM model, delivery scoreboard, immediate-assertion checks.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_instr;
  logic [15:0] ir_pc;
  logic [15:0] ir_pc_next;
  logic        halted;
  logic [15:0] perf_fetches;
  logic [15:0] perf_stalls;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {logic [15:0] pc; logic [15:0] instr;} exp_t;
  exp_t sb[$];

  logic [15:0] rom [16] = '{16'h8180, 16'h2CB2, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                            16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA,
                            16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE};

  assign instruction = (pc < 16'd32) ? rom[pc[4:1]] : 16'hDEAD;

  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr),
    .ir_pc(ir_pc), .ir_pc_next(ir_pc_next), .halted(halted),
    .perf_fetches(perf_fetches), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a);
    exp_t e;
    e.pc = a;
    e.instr = rom[a[4:1]];
    sb.push_back(e);
  endtask

  // Inputs change 1 after negedge; handshake is stable from +3 until the posedge.
  always @(negedge clk) begin
    #3;
    if (rst_n && ir_valid && ir_ready && !redirect_valid) begin
      exp_t e;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_bad++;
        $error("FAIL deliver_extra: observed ir_pc %h expected no delivery", ir_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("deliver_pc", ir_pc, e.pc);
        chk("deliver_instr", ir_instr, e.instr);
      end
    end
  end

  initial begin
    logic [15:0] exp_stalls, exp_fetches;
`ifdef FETCH_PERF_EN
    exp_stalls = 16'd3;
    exp_fetches = 16'd8;
`else
    exp_stalls = 16'd0;
    exp_fetches = 16'd0;
`endif
    ir_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;

    // reset state
    @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_valid", {15'd0, ir_valid}, 16'd0);
    chk("rst_instr", ir_instr, 16'h0000);
    chk("rst_ir_pc", ir_pc, 16'h0000);
    chk("rst_ir_pc_next", ir_pc_next, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_perf_f", perf_fetches, 16'h0000);
    chk("rst_perf_s", perf_stalls, 16'h0000);
    #1 rst_n = 1'b1;
    push(16'd0);

    // BOOT cycle then first fetches
    @(negedge clk);
    chk("boot_pc", pc, 16'h0000);
    chk("boot_valid", {15'd0, ir_valid}, 16'd0);
    @(negedge clk);
    chk("f0_valid", {15'd0, ir_valid}, 16'd1);
    chk("f0_instr", ir_instr, 16'h8180);
    chk("f0_ir_pc", ir_pc, 16'h0000);
    chk("f0_ir_pc_next", ir_pc_next, 16'h0002);
    chk("f0_pc", pc, 16'h0002);
    @(negedge clk);
    chk("f1_instr", ir_instr, 16'h2CB2);
    chk("f1_ir_pc", ir_pc, 16'h0002);
    chk("f1_pc", pc, 16'h0004);
    #1 ir_ready = 1'b0;

    // stall three cycles
    repeat (3) begin
      @(negedge clk);
      chk("stall_instr", ir_instr, 16'h2CB2);
      chk("stall_ir_pc", ir_pc, 16'h0002);
      chk("stall_pc", pc, 16'h0004);
      chk("stall_valid", {15'd0, ir_valid}, 16'd1);
    end
    chk("perf_stalls", perf_stalls, exp_stalls);

    // redirect while stalled: flush, bit0 cleared
    #1 begin redirect_valid = 1'b1; redirect_pc = 16'h0005; end
    @(negedge clk);
    chk("redir_valid", {15'd0, ir_valid}, 16'd0);
    chk("redir_pc", pc, 16'h0004);
    #1 begin redirect_valid = 1'b0; ir_ready = 1'b1; end
    for (int a = 4; a <= 30; a += 2) push(16'(a));
    @(negedge clk);
    chk("redir_ir_pc", ir_pc, 16'h0004);
    chk("redir_ir_valid", {15'd0, ir_valid}, 16'd1);
    chk("redir_pc2", pc, 16'h0006);

    // free run to the limit
    for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
    chk("halt_flag", {15'd0, halted}, 16'd1);
    chk("halt_pc", pc, 16'd32);
    chk("halt_drained", {15'd0, ir_valid}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    chk("halt_pc_hold", pc, 16'd32);
    chk("halt_hold", {15'd0, halted}, 16'd1);
    chk("halt_sb_empty", 16'(sb.size()), 16'd0);

    // resume from halt via redirect
    #1 begin redirect_valid = 1'b1; redirect_pc = 16'h0002; end
    push(16'd2); push(16'd4); push(16'd6);
    @(negedge clk);
    chk("resume_halted", {15'd0, halted}, 16'd0);
    chk("resume_pc", pc, 16'h0002);
    chk("resume_valid", {15'd0, ir_valid}, 16'd0);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("resume_ir_pc", ir_pc, 16'h0002);
    chk("resume_instr", ir_instr, 16'h2CB2);
    chk("resume_ir_pc_next", ir_pc_next, 16'h0004);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_ir_pc", ir_pc, 16'h0008);
    chk("pre_rst_pc", pc, 16'd10);
    #1 ir_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_stall_pc", pc, 16'd10);

    // asynchronous reset mid-stall, checked before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_valid", {15'd0, ir_valid}, 16'd0);
    chk("arst_halted", {15'd0, halted}, 16'd0);
    chk("arst_instr", ir_instr, 16'h0000);
    chk("arst_sb_empty", 16'(sb.size()), 16'd0);

    // release with a redirect during BOOT (ignored), then 8 loads
    @(negedge clk);
    #1 begin rst_n = 1'b1; ir_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0010; end
    for (int a = 0; a <= 12; a += 2) push(16'(a));
    @(negedge clk);
    chk("boot_redir_pc", pc, 16'h0000);
    #1 redirect_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("run8_pc", pc, 16'd16);
    chk("run8_ir_pc", ir_pc, 16'd14);
    chk("perf_fetches", perf_fetches, exp_fetches);
    #1 ir_ready = 1'b0;
    @(negedge clk);
    chk("end_sb_empty", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
